// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a split request/response memory port, bounded
// outstanding requests and an in-order fetch queue feeding decode.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int unsigned FQ_DEPTH        = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic        br_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_pc   [FQ_DEPTH];
    logic [31:0]      r_inst [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] r_filled;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_fill;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_pending;
    logic [CNT_W-1:0] r_discard;

    logic             w_has_room;
    logic             w_has_credit;
    logic             w_accept;
    logic             w_drop;
    logic             w_fill;
    logic             w_pop;
    logic [31:0]      w_target;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_pending_nxt;
    logic [CNT_W-1:0] w_discard_nxt;

    // Request gating: queue space plus an outstanding-request budget that
    // also covers responses still owed to an abandoned path.
    assign w_has_room   = r_count < CNT_W'(FQ_DEPTH);
    assign w_has_credit = (SUM_W'(r_pending) + SUM_W'(r_discard)) < SUM_W'(MAX_OUTSTANDING);
    assign inst_req     = ~reset & ~br_stall & ~br_taken & w_has_room & w_has_credit;
    assign inst_addr    = r_fetch_pc;
    assign w_accept     = inst_req & inst_addr_ok;

    // A response is dropped while old-path responses are owed, or when it
    // coincides with a redirect.
    assign w_drop = inst_data_ok & (r_discard != '0);
    assign w_fill = inst_data_ok & (r_discard == '0) & ~br_taken;

    assign fs_to_ds_valid = r_filled[r_head] & ~br_taken;
    assign fs_to_ds_bus   = {r_inst[r_head], r_pc[r_head]};
    assign w_pop          = fs_to_ds_valid & ds_allowin;

    assign w_target = br_target & 32'hffff_fffc;

    always_comb begin
        w_count_nxt   = r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
        w_pending_nxt = r_pending + CNT_W'(w_accept) - CNT_W'(w_fill);
        w_discard_nxt = r_discard - CNT_W'(w_drop);
        if (br_taken) begin
            w_discard_nxt = r_discard + r_pending - CNT_W'(inst_data_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_pc       <= '{default: '0};
            r_inst     <= '{default: '0};
            r_filled   <= '0;
            r_head     <= '0;
            r_fill     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_pending  <= '0;
            r_discard  <= '0;
        end else if (br_taken) begin
            // Flush everything; outstanding requests become discards.
            r_fetch_pc <= w_target;
            r_filled   <= '0;
            r_head     <= '0;
            r_fill     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_pending  <= '0;
            r_discard  <= w_discard_nxt;
        end else begin
            if (w_accept) begin
                r_pc[r_tail]     <= r_fetch_pc;
                r_filled[r_tail] <= 1'b0;
                r_tail           <= r_tail + PTR_W'(1);
                r_fetch_pc       <= r_fetch_pc + 32'd4;
            end
            if (w_pop) begin
                r_filled[r_head] <= 1'b0;
                r_head           <= r_head + PTR_W'(1);
            end
            if (w_fill) begin
                r_inst[r_fill]   <= inst_rdata;
                r_filled[r_fill] <= 1'b1;
                r_fill           <= r_fill + PTR_W'(1);
            end
            r_count   <= w_count_nxt;
            r_pending <= w_pending_nxt;
            r_discard <= w_discard_nxt;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios plus random traffic against a
// queue-level model of the architectural fetch stream and a memory model.
module tb_if_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam int FQ_DEPTH = 4;
    localparam int MAX_OUT  = 2;

    logic        clk;
    logic        reset;
    logic        ds_allowin;
    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    if_fetch_queue #(
        .RESET_PC(RESET_PC),
        .FQ_DEPTH(FQ_DEPTH),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ds_allowin(ds_allowin),
        .br_stall(br_stall),
        .br_taken(br_taken),
        .br_target(br_target),
        .fs_to_ds_valid(fs_to_ds_valid),
        .fs_to_ds_bus(fs_to_ds_bus),
        .inst_req(inst_req),
        .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } mreq_t;

    int nerr = 0;
    int nchk = 0;
    int cyc  = 0;

    // Memory model: accepted, not yet answered requests (incl. old-path ones)
    mreq_t       mem_q[$];
    // Architectural model: allocated pcs since last redirect, oldest first
    logic [31:0] m_fq[$];
    int          m_nfilled;
    int          m_ndisc;
    logic [31:0] m_req_pc;

    int k_addr_pct = 100;
    int k_data_pct = 100;
    int k_lat_max  = 1;

    logic        obs_req, obs_acc, obs_valid, obs_dok;
    logic [31:0] obs_addr, obs_pc, obs_inst;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'ha5c3_3c5a;
    endfunction

    // One clock: drive memory, check at negedge against the model, advance.
    task automatic cycle();
        logic  exp_req;
        logic  exp_valid;
        logic  acc;
        logic  dok;
        mreq_t r;
        inst_addr_ok = ($urandom_range(99) < k_addr_pct);
        dok = (mem_q.size() > 0) && (mem_q[0].rdy <= cyc) && ($urandom_range(99) < k_data_pct);
        inst_data_ok = dok;
        inst_rdata   = dok ? inst_of(mem_q[0].addr) : $urandom();
        @(negedge clk);
        exp_req = !br_stall && !br_taken && (m_fq.size() < FQ_DEPTH) && (mem_q.size() < MAX_OUT);
        nchk++;
        if (inst_req !== exp_req) begin
            nerr++;
            $display("FAIL inst_req cyc=%0d got=%b exp=%b", cyc, inst_req, exp_req);
        end
        nchk++;
        if (inst_addr !== m_req_pc) begin
            nerr++;
            $display("FAIL inst_addr cyc=%0d got=%h exp=%h", cyc, inst_addr, m_req_pc);
        end
        exp_valid = (m_nfilled > 0) && !br_taken;
        nchk++;
        if (fs_to_ds_valid !== exp_valid) begin
            nerr++;
            $display("FAIL fs_valid cyc=%0d got=%b exp=%b", cyc, fs_to_ds_valid, exp_valid);
        end
        if (exp_valid && fs_to_ds_valid === 1'b1) begin
            nchk++;
            if (fs_to_ds_bus !== {inst_of(m_fq[0]), m_fq[0]}) begin
                nerr++;
                $display("FAIL fs_bus cyc=%0d got=%h exp=%h", cyc, fs_to_ds_bus, {inst_of(m_fq[0]), m_fq[0]});
            end
        end
        acc       = (inst_req === 1'b1) && inst_addr_ok;
        obs_req   = inst_req;
        obs_addr  = inst_addr;
        obs_acc   = acc;
        obs_valid = fs_to_ds_valid;
        obs_pc    = fs_to_ds_bus[31:0];
        obs_inst  = fs_to_ds_bus[63:32];
        obs_dok   = dok;
        if (acc) begin
            mem_q.push_back('{addr: m_req_pc, rdy: cyc + int'($urandom_range(k_lat_max, 1))});
            m_fq.push_back(m_req_pc);
            m_req_pc = m_req_pc + 32'd4;
        end
        if (exp_valid && ds_allowin) begin
            void'(m_fq.pop_front());
            m_nfilled--;
        end
        if (dok) begin
            r = mem_q.pop_front();
            if (!br_taken) begin
                if (m_ndisc > 0) m_ndisc--;
                else m_nfilled++;
            end
        end
        if (br_taken) begin
            m_fq.delete();
            m_nfilled = 0;
            m_ndisc   = mem_q.size();
            m_req_pc  = br_target & 32'hffff_fffc;
        end
        nchk++;
        if (mem_q.size() > MAX_OUT) begin
            nerr++;
            $display("FAIL outstanding cyc=%0d got=%0d max=%0d", cyc, mem_q.size(), MAX_OUT);
        end
        nchk++;
        if (m_fq.size() > FQ_DEPTH) begin
            nerr++;
            $display("FAIL overflow cyc=%0d got=%0d max=%0d", cyc, m_fq.size(), FQ_DEPTH);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ds_allowin = 1'b0; br_stall = 1'b0; br_taken = 1'b0; br_target = '0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        mem_q.delete();
        m_fq.delete();
        m_nfilled = 0;
        m_ndisc   = 0;
        m_req_pc  = RESET_PC;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ds_allowin = 1'b1; br_stall = 1'b0; br_taken = 1'b0; br_target = '0;
        inst_addr_ok = 1'b1; inst_data_ok = 1'b0; inst_rdata = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        nchk++;
        if (inst_req !== 1'b0) begin nerr++; $display("FAIL reset_req got=%b exp=0", inst_req); end
        nchk++;
        if (inst_addr !== RESET_PC) begin nerr++; $display("FAIL reset_addr got=%h exp=%h", inst_addr, RESET_PC); end
        nchk++;
        if (fs_to_ds_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%b exp=0", fs_to_ds_valid); end
        nchk++;
        if (fs_to_ds_bus !== 64'h0) begin nerr++; $display("FAIL reset_bus got=%h exp=0", fs_to_ds_bus); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_seq_fetch();
        do_reset();
        k_addr_pct = 100; k_data_pct = 100; k_lat_max = 1;
        ds_allowin = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (i < 3) begin
                nchk++;
                if (obs_req !== 1'b1 || obs_addr !== RESET_PC + 32'(4 * i)) begin
                    nerr++;
                    $display("FAIL seq_req i=%0d got=%b/%h exp=1/%h", i, obs_req, obs_addr, RESET_PC + 32'(4 * i));
                end
            end
            if (i >= 2) begin
                nchk++;
                if (obs_valid !== 1'b1 || obs_pc !== RESET_PC + 32'(4 * (i - 2))) begin
                    nerr++;
                    $display("FAIL seq_decode i=%0d got=%b/%h exp=1/%h", i, obs_valid, obs_pc, RESET_PC + 32'(4 * (i - 2)));
                end
            end
        end
    endtask

    task automatic test_full_queue();
        int n_acc;
        do_reset();
        k_addr_pct = 100; k_data_pct = 100; k_lat_max = 1;
        ds_allowin = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (obs_acc) n_acc++;
            if (i >= 4) begin
                nchk++;
                if (obs_req !== 1'b0) begin nerr++; $display("FAIL full_req i=%0d got=%b exp=0", i, obs_req); end
            end
        end
        nchk++;
        if (n_acc != FQ_DEPTH) begin nerr++; $display("FAIL full_accepts got=%0d exp=%0d", n_acc, FQ_DEPTH); end
        ds_allowin = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i == 0) begin
                nchk++;
                if (obs_req !== 1'b0) begin nerr++; $display("FAIL drain_req0 got=%b exp=0", obs_req); end
            end
            if (i == 1) begin
                nchk++;
                if (obs_req !== 1'b1 || obs_addr !== RESET_PC + 32'd16) begin
                    nerr++;
                    $display("FAIL drain_resume got=%b/%h exp=1/%h", obs_req, obs_addr, RESET_PC + 32'd16);
                end
            end
            if (i < 4) begin
                nchk++;
                if (obs_valid !== 1'b1 || obs_pc !== RESET_PC + 32'(4 * i) || obs_inst !== inst_of(RESET_PC + 32'(4 * i))) begin
                    nerr++;
                    $display("FAIL drain_order i=%0d got=%b/%h/%h exp pc=%h", i, obs_valid, obs_pc, obs_inst, RESET_PC + 32'(4 * i));
                end
            end
        end
    endtask

    // Redirect with two old-path requests outstanding; br_cyc selects
    // whether the first old response coincides with the redirect.
    task automatic run_redirect(input string nm, input logic [31:0] tgt, input int data_on);
        int          n_dok;
        logic        seen;
        logic        got_acc;
        logic [31:0] first_acc;
        logic [31:0] tgt_al;
        do_reset();
        tgt_al = tgt & 32'hffff_fffc;
        k_addr_pct = 100; k_lat_max = 1;
        ds_allowin = 1'b1;
        n_dok = 0; seen = 1'b0; got_acc = 1'b0; first_acc = '0;
        for (int i = 0; i < 12; i++) begin
            br_taken   = (i == 2);
            br_target  = tgt;
            k_data_pct = (i >= data_on) ? 100 : 0;
            cycle();
            if (i == 3) begin
                nchk++;
                if (obs_addr !== tgt_al) begin nerr++; $display("FAIL %s_addr got=%h exp=%h", nm, obs_addr, tgt_al); end
            end
            if (i >= 3 && obs_acc && !got_acc) begin
                got_acc = 1'b1;
                first_acc = obs_addr;
            end
            if (i >= 3 && obs_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                nchk++;
                if (obs_pc !== tgt_al || obs_inst !== inst_of(tgt_al)) begin
                    nerr++;
                    $display("FAIL %s_first got=%h/%h exp=%h/%h", nm, obs_pc, obs_inst, tgt_al, inst_of(tgt_al));
                end
            end
            if (i >= 2 && !seen && obs_dok) n_dok++;
        end
        br_taken = 1'b0;
        nchk++;
        if (!got_acc || first_acc !== tgt_al) begin nerr++; $display("FAIL %s_req got=%h exp=%h", nm, first_acc, tgt_al); end
        nchk++;
        if (!seen) begin nerr++; $display("FAIL %s_seen got=0 exp=1", nm); end
        nchk++;
        if (n_dok != 3) begin nerr++; $display("FAIL %s_drops got=%0d exp=3", nm, n_dok); end
    endtask

    task automatic test_redirect();
        run_redirect("redir", 32'h1c000103, 3);
    endtask

    task automatic test_redirect_same_cycle();
        run_redirect("redir_same", 32'h1c000200, 2);
    endtask

    task automatic test_stall();
        int nv;
        do_reset();
        k_addr_pct = 100; k_lat_max = 1;
        ds_allowin = 1'b1;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            br_stall   = (i >= 2 && i <= 6);
            k_data_pct = (i >= 2) ? 100 : 0;
            cycle();
            if (i >= 2 && i <= 6) begin
                nchk++;
                if (obs_req !== 1'b0) begin nerr++; $display("FAIL stall_req i=%0d got=%b exp=0", i, obs_req); end
            end
            if (i >= 2 && i <= 7 && obs_valid === 1'b1) begin
                nchk++;
                if (obs_pc !== RESET_PC + 32'(4 * nv)) begin
                    nerr++;
                    $display("FAIL stall_order got=%h exp=%h", obs_pc, RESET_PC + 32'(4 * nv));
                end
                nv++;
            end
            if (i == 7) begin
                nchk++;
                if (obs_req !== 1'b1 || obs_addr !== RESET_PC + 32'd8) begin
                    nerr++;
                    $display("FAIL stall_resume got=%b/%h exp=1/%h", obs_req, obs_addr, RESET_PC + 32'd8);
                end
            end
        end
        br_stall = 1'b0;
        nchk++;
        if (nv != 2) begin nerr++; $display("FAIL stall_delivered got=%0d exp=2", nv); end
    endtask

    task automatic test_random();
        int npop;
        do_reset();
        k_addr_pct = 70; k_data_pct = 60; k_lat_max = 3;
        npop = 0;
        for (int i = 0; i < 3000; i++) begin
            ds_allowin = ($urandom_range(99) < 70);
            br_stall   = ($urandom_range(99) < 10);
            br_taken   = ($urandom_range(99) < 3);
            br_target  = $urandom();
            cycle();
            if (obs_valid === 1'b1 && ds_allowin) npop++;
        end
        br_taken = 1'b0; br_stall = 1'b0;
        nchk++;
        if (npop < 100) begin nerr++; $display("FAIL random_progress got=%0d exp>=100", npop); end
    endtask

    initial begin
        reset = 1'b1;
        ds_allowin = 1'b0; br_stall = 1'b0; br_taken = 1'b0; br_target = '0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
        m_nfilled = 0; m_ndisc = 0; m_req_pc = RESET_PC;
        @(posedge clk);
        #1;
        test_reset();
        test_seq_fetch();
        test_full_queue();
        test_redirect();
        test_redirect_same_cycle();
        test_stall();
        test_random();
        test_reset();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage with a split request/response instruction-memory port, a configurable number of outstanding requests, and an in-order fetch queue that decouples memory latency from decode back-pressure. It sits between the branch/hazard logic and the ID stage. It drives the same `{inst, pc}` bus and valid/allowin handshake toward decode as the single-entry IF stage. Branch redirects flush the queue and silently drop in-flight responses from the wrong path.

## Interface
Parameters:
- `RESET_PC`, default 32'h1c000000: first fetch address after reset.
- `FQ_DEPTH`, default 4: fetch-queue entries; power of two, ≥2.
- `MAX_OUTSTANDING`, default 2: maximum requests accepted but not yet answered, including discarded ones; 1..FQ_DEPTH.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `ds_allowin`  in  1: decode can accept an instruction this cycle.
- `br_stall`  in  1: suppress new memory requests; queue and responses keep running.
- `br_taken`  in  1: redirect fetch to `br_target` this cycle.
- `br_target`  in  32: redirect address; bits [1:0] are ignored and forced to 0.
- `fs_to_ds_valid`  out  1: head entry valid toward decode.
- `fs_to_ds_bus`  out  64: {inst[63:32], pc[31:0]} of the head entry.
- `inst_req`  out  1: memory request valid.
- `inst_addr`  out  32: request address (= fetch_pc).
- `inst_addr_ok`  in  1: request accepted this cycle (qualified by `inst_req`).
- `inst_data_ok`  in  1: one in-order response returned this cycle.
- `inst_rdata`  in  32: response data, valid with `inst_data_ok`.

## Operation
- State:
  - `fetch_pc` (32).
  - Queue of FQ_DEPTH entries {pc, inst, filled}, with head, fill and tail pointers.
  - `count` (allocated entries).
  - `pending` (allocated, unfilled).
  - `discard` (responses to drop).
- Request: `inst_req = ~reset & ~br_stall & ~br_taken & (count < FQ_DEPTH) & (pending + discard < MAX_OUTSTANDING)`.
- Accept (`inst_req & inst_addr_ok`): allocate tail entry with pc = `fetch_pc`, filled = 0; `fetch_pc += 4` (32-bit wrap, no trap); `tail++`, `count++`, `pending++`.
- Response (`inst_data_ok`):
  - If `discard > 0`: `discard--` and the data is dropped.
  - Otherwise: write `inst_rdata` into the entry at the fill pointer, set filled, `fill++`, `pending--`.
  - Responses are in order; the memory never returns more responses than were accepted.
- Output: `fs_to_ds_valid = head.filled & ~br_taken`. Pop when `fs_to_ds_valid & ds_allowin`: `head++`, `count--`.
- Redirect (`br_taken`):
  - Next cycle: `fetch_pc = {br_target[31:2], 2'b00}`.
  - All entries are invalidated: count = 0, pointers equal, filled cleared.
  - `discard = discard + pending − (inst_data_ok ? 1 : 0)`; the same-cycle response is treated as old-path and dropped.
  - `pending = 0`.
  - No pop and no request in the redirect cycle.
- Simultaneous pop, fill and accept in one cycle are all legal; `count` and `pending` update by the net sum.
- `br_stall` together with `br_taken`: the redirect still takes effect; only requests are blocked.
- Pointers wrap modulo FQ_DEPTH.

## Timing
- Reset values:
  - `inst_req` = 0, `inst_addr` = RESET_PC.
  - `fs_to_ds_valid` = 0, `fs_to_ds_bus` = 0.
  - count = pending = discard = 0.
- Reset mid-operation clears all state. The memory side is reset in the same cycle, so no responses from before reset arrive.
- First request is in the first cycle after reset deassertion, with address RESET_PC.
- Memory contract: `inst_data_ok` for a request comes no earlier than the cycle after its `inst_addr_ok`.
- Fill to output latency: `inst_data_ok` in cycle N makes `fs_to_ds_valid` = 1 in N+1 (registered; no bypass).
- Zero-wait memory (addr_ok always 1, data_ok one cycle later) with `ds_allowin` = 1 sustains 1 instruction/cycle once MAX_OUTSTANDING ≥ 2.
- Redirect: `br_taken` in cycle N gives `inst_addr` = target in N+1. The earliest valid target instruction is in N+3 under zero-wait memory with `discard` = 0.
- Full queue (`count` = FQ_DEPTH): `inst_req` = 0 until a pop. A pop in cycle N allows a request in N+1.

## Test plan
- Reset release, memory always-ready with 1-cycle data:
  - `inst_addr` = 1c000000, 1c000004, 1c000008 on consecutive cycles.
  - Decode sees pc 1c000000 two cycles after the first request, then one instruction per cycle.
- Hold `ds_allowin` = 0 for 10 cycles:
  - Exactly FQ_DEPTH (4) requests are accepted, then `inst_req` stays 0.
  - On release, the 4 instructions drain in order with correct pc/inst pairing, and requests resume the cycle after the first pop.
- `br_taken` with target 1c000103 while 2 requests are pending:
  - The next 2 `inst_data_ok` are dropped, and no old-path pc reaches decode.
  - First new request address is 1c000100.
  - Decode receives pc 1c000100 first.
- `br_taken` in the same cycle as `inst_data_ok`:
  - That response is dropped.
  - `discard` = pending−1, checked by counting the subsequently dropped responses.
- `br_stall` = 1 for 5 cycles with 2 responses outstanding:
  - No new `inst_req`.
  - Both responses are queued and delivered.
  - Fetch resumes at the correct sequential pc.
- Random `addr_ok`/`data_ok` delays with random `ds_allowin` and branches; the scoreboard checks:
  - Decode pc sequence = architectural sequence.
  - Outstanding requests never exceed MAX_OUTSTANDING.
  - No overflow.
